ads1118_spi_responder: RTL and testbench

ADS1118_SPI_RESPONDER -- requirements
Module: ads1118_spi_responder

---
 rtl/ads1118_spi_responder.sv | 153 +++++++++++++++
 tb/tb_ads1118_spi_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads1118_spi_responder.sv
// ADS1118-style SPI slave: shifts out conversion codes, captures config words.
// All SPI pins are synchronized into the 50 MHz domain before use.
`timescale 1ns/1ps
module ads1118_spi_responder (
  input  logic        CLK_50M,
  input  logic        rst,
  input  logic        sclk,
  input  logic        CS,
  input  logic        DIN,
  output logic        DOUT,
  input  logic [15:0] sample_data,
  input  logic        sample_valid,
  output logic [15:0] cfg_word,
  output logic        cfg_valid,
  output logic        frame_err,
  output logic        data_ready
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  logic [1:0]  r_sclk_s;
  logic [1:0]  r_cs_s;
  logic [1:0]  r_din_s;
  logic        r_sclk_d;
  logic        r_cs_d;

  state_t      r_state;
  logic [14:0] r_tx;
  logic [15:0] r_rx;
  logic [5:0]  r_bitcnt;
  logic        r_first;
  logic [15:0] r_pending;
  logic        r_dout;
  logic [15:0] r_cfg;
  logic        r_cfg_valid;
  logic        r_frame_err;
  logic        r_data_ready;

  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic        w_cs_rise;
  logic        w_cs_fall;
  logic        w_din;
  logic [15:0] w_result;

  // Two-flop synchronizers plus one edge-detect stage. CS resets to the
  // "low" value so a frame already running at reset release never shows
  // a falling edge until CS has first been seen high.
  always_ff @(posedge CLK_50M) begin
    if (rst) begin
      r_sclk_s <= 2'b00;
      r_cs_s   <= 2'b00;
      r_din_s  <= 2'b00;
      r_sclk_d <= 1'b0;
      r_cs_d   <= 1'b0;
    end else begin
      r_sclk_s <= {r_sclk_s[0], sclk};
      r_cs_s   <= {r_cs_s[0], CS};
      r_din_s  <= {r_din_s[0], DIN};
      r_sclk_d <= r_sclk_s[1];
      r_cs_d   <= r_cs_s[1];
    end
  end

  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_d;
  assign w_cs_rise   = r_cs_s[1] & ~r_cs_d;
  assign w_cs_fall   = ~r_cs_s[1] & r_cs_d;
  assign w_din       = r_din_s[1];

  // A sample arriving on the frame-start cycle wins over the pending one.
  assign w_result = sample_valid ? sample_data : r_pending;

  // Frame FSM: load on CS fall, shift on sclk edges, evaluate on CS rise.
  always_ff @(posedge CLK_50M) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_tx         <= 15'h0000;
      r_rx         <= 16'h0000;
      r_bitcnt     <= 6'd0;
      r_first      <= 1'b0;
      r_pending    <= 16'h0000;
      r_dout       <= 1'b0;
      r_cfg        <= 16'h058B;
      r_cfg_valid  <= 1'b0;
      r_frame_err  <= 1'b0;
      r_data_ready <= 1'b0;
    end else begin
      r_cfg_valid <= 1'b0;
      r_frame_err <= 1'b0;
      if (sample_valid) begin
        r_pending    <= sample_data;
        r_data_ready <= 1'b1;
      end
      unique case (r_state)
        ST_IDLE: begin
          r_dout <= 1'b0;
          if (w_cs_fall) begin
            r_state      <= ST_SHIFT;
            r_tx         <= w_result[14:0];
            r_dout       <= w_result[15];
            r_rx         <= 16'h0000;
            r_bitcnt     <= 6'd0;
            r_first      <= 1'b1;
            r_data_ready <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (w_cs_rise) begin
            r_state <= ST_DONE;
            r_dout  <= 1'b0;
          end else if (w_sclk_rise) begin
            // MSB is already on the pin, so the first rise only arms shifting.
            r_first <= 1'b0;
            if (!r_first) begin
              r_tx   <= {r_tx[13:0], 1'b0};
              r_dout <= r_tx[14];
            end
          end else if (w_sclk_fall) begin
            r_rx <= {r_rx[14:0], w_din};
            if (r_bitcnt != 6'd63) begin
              r_bitcnt <= r_bitcnt + 6'd1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          if (r_bitcnt == 6'd16) begin
            // NOP field must be 01 for a write; bit 0 is reserved, reads as 1.
            if (r_rx[2:1] == 2'b01) begin
              r_cfg       <= r_rx | 16'h0001;
              r_cfg_valid <= 1'b1;
            end
          end else begin
            r_frame_err <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign DOUT       = r_dout;
  assign cfg_word   = r_cfg;
  assign cfg_valid  = r_cfg_valid;
  assign frame_err  = r_frame_err;
  assign data_ready = r_data_ready;

endmodule

// File: tb/tb_ads1118_spi_responder.sv
// Bench for ads1118_spi_responder: directed table, reset-in-frame
// sequence and randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_ads1118_spi_responder;

  logic        CLK_50M = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        CS = 1'b1;
  logic        DIN = 1'b0;
  logic        DOUT;
  logic [15:0] sample_data = 16'h0000;
  logic        sample_valid = 1'b0;
  logic [15:0] cfg_word;
  logic        cfg_valid;
  logic        frame_err;
  logic        data_ready;

  int checks = 0;
  int errors = 0;
  int n_cv = 0;
  int n_fe = 0;

  typedef struct {
    int          n;
    logic [15:0] din;
    bit          pre;
    logic [15:0] pdat;
    bit          svf;
    logic [15:0] sdat;
    logic [31:0] e_got;
    logic [15:0] e_cfg;
    int          e_cv;
    int          e_fe;
    bit          e_dr;
  } vec_t;

  vec_t tbl[8];

  logic [15:0] m_pend;
  logic [15:0] m_cfg;
  bit          m_dr;

  ads1118_spi_responder dut (
    .CLK_50M      (CLK_50M),
    .rst          (rst),
    .sclk         (sclk),
    .CS           (CS),
    .DIN          (DIN),
    .DOUT         (DOUT),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .cfg_word     (cfg_word),
    .cfg_valid    (cfg_valid),
    .frame_err    (frame_err),
    .data_ready   (data_ready)
  );

  always #10 CLK_50M = ~CLK_50M;

  // Count high cycles, so a stretched pulse shows up as a count above 1.
  always @(posedge CLK_50M) begin
    if (cfg_valid) n_cv <= n_cv + 1;
    if (frame_err) n_fe <= n_fe + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: sim still running, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic load(input logic [15:0] d);
    @(negedge CLK_50M);
    sample_data  = d;
    sample_valid = 1'b1;
    @(negedge CLK_50M);
    sample_valid = 1'b0;
  endtask

  task automatic frame(input int n, input logic [15:0] din,
                       input bit svf, input logic [15:0] sdat,
                       input bit mid, input logic [15:0] mdat,
                       output logic [31:0] got);
    got = 32'h0;
    @(negedge CLK_50M);
    CS = 1'b0;
    if (svf) begin
      repeat (2) @(posedge CLK_50M);
      @(negedge CLK_50M);
      sample_data  = sdat;
      sample_valid = 1'b1;
      @(negedge CLK_50M);
      sample_valid = 1'b0;
      #440;
    end else begin
      #500;
    end
    for (int i = 0; i < n; i++) begin
      DIN  = (i < 16) ? din[15-i] : 1'b0;
      sclk = 1'b1;
      if (mid && i == 4) begin
        @(negedge CLK_50M);
        sample_data  = mdat;
        sample_valid = 1'b1;
        @(negedge CLK_50M);
        sample_valid = 1'b0;
        #460;
      end else begin
        #500;
      end
      got  = {got[30:0], DOUT};
      sclk = 1'b0;
      #500;
    end
    CS = 1'b1;
    repeat (10) @(posedge CLK_50M);
    @(negedge CLK_50M);
  endtask

  task automatic exec(input int idx, input int n, input logic [15:0] din,
                      input bit pre, input logic [15:0] pdat,
                      input bit svf, input logic [15:0] sdat,
                      input bit mid, input logic [15:0] mdat,
                      input logic [31:0] e_got, input logic [15:0] e_cfg,
                      input int e_cv, input int e_fe, input bit e_dr);
    logic [31:0] got;
    int cv0;
    int fe0;
    if (pre) begin
      load(pdat);
      check("dr_loaded", idx, {31'h0, data_ready}, 32'h1);
    end
    cv0 = n_cv;
    fe0 = n_fe;
    frame(n, din, svf, sdat, mid, mdat, got);
    check("dout_bits", idx, got, e_got);
    check("cfg_word", idx, {16'h0, cfg_word}, {16'h0, e_cfg});
    check("cfg_valid_cnt", idx, n_cv - cv0, e_cv);
    check("frame_err_cnt", idx, n_fe - fe0, e_fe);
    check("data_ready", idx, {31'h0, data_ready}, {31'h0, e_dr});
    check("dout_idle", idx, {31'h0, DOUT}, 32'h0);
  endtask

  initial begin
    logic [31:0] got;
    int cv0;
    int fe0;

    tbl[0] = '{16, 16'h8580, 1'b1, 16'h7FF0, 1'b0, 16'h0000,
               32'h7FF0, 16'h058B, 0, 0, 1'b0};
    tbl[1] = '{16, 16'h8A3A, 1'b0, 16'h0000, 1'b0, 16'h0000,
               32'h7FF0, 16'h8A3B, 1, 0, 1'b0};
    tbl[2] = '{10, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000,
               32'h01FF, 16'h8A3B, 0, 1, 1'b0};
    tbl[3] = '{16, 16'hC3EA, 1'b0, 16'h0000, 1'b0, 16'h0000,
               32'h7FF0, 16'hC3EB, 1, 0, 1'b0};
    tbl[4] = '{0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000,
               32'h0000, 16'hC3EB, 0, 1, 1'b0};
    tbl[5] = '{17, 16'hC3EA, 1'b0, 16'h0000, 1'b0, 16'h0000,
               32'hFFE0, 16'hC3EB, 0, 1, 1'b0};
    tbl[6] = '{16, 16'h1234, 1'b0, 16'h0000, 1'b1, 16'h8001,
               32'h8001, 16'hC3EB, 0, 0, 1'b0};
    tbl[7] = '{16, 16'h8A3A, 1'b1, 16'h5A5A, 1'b0, 16'h0000,
               32'h5A5A, 16'h8A3B, 1, 0, 1'b0};

    rst = 1'b1;
    repeat (5) @(posedge CLK_50M);
    @(negedge CLK_50M);
    rst = 1'b0;
    repeat (5) @(negedge CLK_50M);
    check("rst_dout", 0, {31'h0, DOUT}, 32'h0);
    check("rst_cfg", 0, {16'h0, cfg_word}, 32'h058B);
    check("rst_cfg_valid", 0, {31'h0, cfg_valid}, 32'h0);
    check("rst_frame_err", 0, {31'h0, frame_err}, 32'h0);
    check("rst_data_ready", 0, {31'h0, data_ready}, 32'h0);

    for (int i = 0; i < 8; i++) begin
      exec(i, tbl[i].n, tbl[i].din, tbl[i].pre, tbl[i].pdat,
           tbl[i].svf, tbl[i].sdat, 1'b0, 16'h0000,
           tbl[i].e_got, tbl[i].e_cfg, tbl[i].e_cv, tbl[i].e_fe,
           tbl[i].e_dr);
    end

    // Reset in the middle of a frame, then finish that frame's clocks.
    load(16'h1111);
    cv0 = n_cv;
    fe0 = n_fe;
    @(negedge CLK_50M);
    CS = 1'b0;
    #500;
    for (int i = 0; i < 8; i++) begin
      DIN  = i[0];
      sclk = 1'b1;
      #500;
      sclk = 1'b0;
      #500;
    end
    rst = 1'b1;
    repeat (3) @(negedge CLK_50M);
    rst = 1'b0;
    @(negedge CLK_50M);
    check("midrst_dout", 20, {31'h0, DOUT}, 32'h0);
    check("midrst_cfg", 20, {16'h0, cfg_word}, 32'h058B);
    check("midrst_dr", 20, {31'h0, data_ready}, 32'h0);
    got = 32'h0;
    for (int i = 0; i < 8; i++) begin
      DIN  = 1'b1;
      sclk = 1'b1;
      #500;
      got  = {got[30:0], DOUT};
      sclk = 1'b0;
      #500;
    end
    CS = 1'b1;
    repeat (10) @(posedge CLK_50M);
    @(negedge CLK_50M);
    check("midrst_tail_dout", 20, got, 32'h0);
    check("midrst_cfg_after", 20, {16'h0, cfg_word}, 32'h058B);
    check("midrst_cv_cnt", 20, n_cv - cv0, 0);
    check("midrst_fe_cnt", 20, n_fe - fe0, 0);

    // Pending was cleared by reset, so the next frame sends zero.
    exec(21, 16, 16'hC3EA, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0,
         32'h0000, 16'hC3EB, 1, 0, 1'b0);

    m_pend = 16'h0000;
    m_cfg  = 16'hC3EB;
    m_dr   = 1'b0;
    for (int k = 0; k < 16; k++) begin
      int          n;
      logic [15:0] din;
      bit          pre;
      logic [15:0] pdat;
      bit          svf;
      logic [15:0] sdat;
      bit          mid;
      logic [15:0] mdat;
      logic [15:0] res;
      logic [31:0] e_got;
      int          e_cv;
      int          e_fe;
      n    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16;
      din  = 16'($urandom);
      if ($urandom_range(0, 1) == 1) din[2:1] = 2'b01;
      pre  = ($urandom_range(0, 1) == 1);
      pdat = 16'($urandom);
      svf  = ($urandom_range(0, 3) == 0);
      sdat = 16'($urandom);
      mid  = ($urandom_range(0, 3) == 0) && (n > 5);
      mdat = 16'($urandom);
      e_cv = 0;
      e_fe = 0;
      if (pre) begin
        m_pend = pdat;
        m_dr   = 1'b1;
      end
      res = svf ? sdat : m_pend;
      if (svf) m_pend = sdat;
      m_dr = 1'b0;
      if (mid) begin
        m_pend = mdat;
        m_dr   = 1'b1;
      end
      if (n <= 16) e_got = 32'(res) >> (16 - n);
      else e_got = 32'(res) << (n - 16);
      if (n == 16) begin
        if (din[2:1] == 2'b01) begin
          m_cfg = din | 16'h0001;
          e_cv  = 1;
        end
      end else begin
        e_fe = 1;
      end
      exec(100 + k, n, din, pre, pdat, svf, sdat, mid, mdat,
           e_got, m_cfg, e_cv, e_fe, m_dr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
